// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the 4-channel PWM time-base.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } pwm_ch_state_t;

    localparam int PWM_NUM_CH = 4;
    localparam int PWM_CNT_W  = 16;
    localparam int PWM_DIV_W  = 8;

endpackage

// File: rtl/pwm_ch_ctrl.sv
// One PWM channel: IDLE/RUN/DRAIN sequencer, period counter,
// boundary-loaded shadows and registered pin/busy/event outputs.
module pwm_ch_ctrl
    import pwm_pkg::*;
#(
    parameter int P_CNT_WIDTH = PWM_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   en,
    input  logic                   inv,
    input  logic [P_CNT_WIDTH-1:0] period,
    input  logic [P_CNT_WIDTH-1:0] duty,
    output logic                   pwm_out,
    output logic                   busy,
    output logic                   pend
);

    pwm_ch_state_t          state_q, state_d;
    logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [P_CNT_WIDTH-1:0] per_q, per_d;
    logic [P_CNT_WIDTH-1:0] duty_q, duty_d;
    logic                   inv_q, inv_d;
    logic                   period_end;
    logic                   act;

    assign period_end = (cnt_q == per_q);
    assign act        = (state_q != IDLE) && (cnt_q < duty_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        duty_d  = duty_q;
        inv_d   = inv_q;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        per_d   = period;
                        duty_d  = duty;
                        inv_d   = inv;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (period_end) begin
                        cnt_d = '0;
                        // only an enabled RUN channel picks up new config
                        if (state_q == RUN && en) begin
                            per_d  = period;
                            duty_d = duty;
                            inv_d  = inv;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d   = cnt_q + P_CNT_WIDTH'(1);
                        state_d = en ? RUN : DRAIN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            duty_q  <= '0;
            inv_q   <= 1'b0;
            pwm_out <= 1'b0;
            busy    <= 1'b0;
            pend    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            duty_q  <= duty_d;
            inv_q   <= inv_d;
            pwm_out <= (state_q == IDLE) ? inv : (act ^ inv_q);
            busy    <= (state_q != IDLE);
            pend    <= tick && (state_q != IDLE) && period_end;
        end
    end

endmodule

// File: rtl/pwm_sched_ctrl.sv
// PWM time-base: shared prescaler tick feeding one sequencer per channel
// sliced out of the flattened period/duty buses.
module pwm_sched_ctrl
    import pwm_pkg::*;
#(
    parameter int P_NUM_CH    = PWM_NUM_CH,
    parameter int P_CNT_WIDTH = PWM_CNT_W,
    parameter int P_DIV_WIDTH = PWM_DIV_W
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic [P_DIV_WIDTH-1:0]          PWM_DIV,
    input  logic [P_NUM_CH-1:0]             PWM_EN,
    input  logic [P_NUM_CH-1:0]             PWM_INV,
    input  logic [P_NUM_CH*P_CNT_WIDTH-1:0] PWM_PERIOD,
    input  logic [P_NUM_CH*P_CNT_WIDTH-1:0] PWM_DUTY,
    output logic [P_NUM_CH-1:0]             PWM_OUT,
    output logic [P_NUM_CH-1:0]             PWM_BUSY,
    output logic [P_NUM_CH-1:0]             PWM_PEND
);

    logic [P_DIV_WIDTH-1:0] div_cnt;
    logic [P_DIV_WIDTH-1:0] div_sh;
    logic                   tick;

    assign tick = (div_cnt == div_sh);

    // divisor is re-sampled only on a tick so an interval never stretches
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            div_cnt <= '0;
            div_sh  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            div_sh  <= PWM_DIV;
        end else begin
            div_cnt <= div_cnt + P_DIV_WIDTH'(1);
        end
    end

    for (genvar i = 0; i < P_NUM_CH; i++) begin : g_ch
        pwm_ch_ctrl #(
            .P_CNT_WIDTH(P_CNT_WIDTH)
        ) u_ch (
            .clk    (PCLK),
            .rst    (PRESET),
            .tick   (tick),
            .en     (PWM_EN[i]),
            .inv    (PWM_INV[i]),
            .period (PWM_PERIOD[i*P_CNT_WIDTH +: P_CNT_WIDTH]),
            .duty   (PWM_DUTY[i*P_CNT_WIDTH +: P_CNT_WIDTH]),
            .pwm_out(PWM_OUT[i]),
            .busy   (PWM_BUSY[i]),
            .pend   (PWM_PEND[i])
        );
    end

endmodule

// File: tb/tb_pwm_sched_ctrl.sv
// Bench for pwm_sched_ctrl: per-cycle reference model plus directed
// sequences with literal expected waveforms.
module tb_pwm_sched_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [7:0]  PWM_DIV;
    logic [3:0]  PWM_EN;
    logic [3:0]  PWM_INV;
    logic [63:0] PWM_PERIOD;
    logic [63:0] PWM_DUTY;
    logic [3:0]  PWM_OUT;
    logic [3:0]  PWM_BUSY;
    logic [3:0]  PWM_PEND;

    pwm_sched_ctrl dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PWM_DIV   (PWM_DIV),
        .PWM_EN    (PWM_EN),
        .PWM_INV   (PWM_INV),
        .PWM_PERIOD(PWM_PERIOD),
        .PWM_DUTY  (PWM_DUTY),
        .PWM_OUT   (PWM_OUT),
        .PWM_BUSY  (PWM_BUSY),
        .PWM_PEND  (PWM_PEND)
    );

    always #5 PCLK = ~PCLK;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // reference model: mode 0 = off, 1 = running, 2 = finishing
    int   m_since, m_intv;
    bit   m_tick;
    int   mode[4], pos[4], mper[4], mduty[4];
    bit   minv[4];
    logic [3:0] e_out, e_busy, e_pend;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_since = 0;
            m_intv  = 0;
            for (int i = 0; i < 4; i++) begin
                mode[i] = 0; pos[i] = 0; mper[i] = 0;
                mduty[i] = 0; minv[i] = 0;
            end
            e_out = '0; e_busy = '0; e_pend = '0;
        end else begin
            m_tick = (m_since == m_intv);
            for (int i = 0; i < 4; i++) begin
                e_busy[i] = (mode[i] != 0);
                e_out[i]  = (mode[i] == 0) ? PWM_INV[i]
                          : ((pos[i] < mduty[i]) ^ minv[i]);
                e_pend[i] = m_tick && mode[i] != 0 && pos[i] == mper[i];
            end
            if (m_tick) begin
                for (int i = 0; i < 4; i++) begin
                    if (mode[i] == 0) begin
                        if (PWM_EN[i]) begin
                            mode[i] = 1; pos[i] = 0;
                            mper[i]  = int'(PWM_PERIOD[i*16 +: 16]);
                            mduty[i] = int'(PWM_DUTY[i*16 +: 16]);
                            minv[i]  = PWM_INV[i];
                        end
                    end else if (pos[i] == mper[i]) begin
                        pos[i] = 0;
                        if (mode[i] == 1 && PWM_EN[i]) begin
                            mper[i]  = int'(PWM_PERIOD[i*16 +: 16]);
                            mduty[i] = int'(PWM_DUTY[i*16 +: 16]);
                            minv[i]  = PWM_INV[i];
                        end else begin
                            mode[i] = 0;
                        end
                    end else begin
                        pos[i]  = pos[i] + 1;
                        mode[i] = PWM_EN[i] ? 1 : 2;
                    end
                end
                m_since = 0;
                m_intv  = int'(PWM_DIV);
            end else begin
                m_since = m_since + 1;
            end
        end
    end

    always @(negedge PCLK) begin
        if (chk_on && !PRESET) begin
            n_chk++;
            if ({PWM_OUT, PWM_BUSY, PWM_PEND} !== {e_out, e_busy, e_pend}) begin
                n_err++;
                $display("FAIL model t=%0t: got out=%b busy=%b pend=%b want out=%b busy=%b pend=%b",
                         $time, PWM_OUT, PWM_BUSY, PWM_PEND, e_out, e_busy, e_pend);
            end
        end
    end

    logic [3:0] co[16], cp[16], cb[16];

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic cap(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge PCLK);
            co[k] = PWM_OUT;
            cp[k] = PWM_PEND;
            cb[k] = PWM_BUSY;
        end
    endtask

    // samples packed oldest-first into the MSB end
    function automatic logic [15:0] pk(input int ch, input int n, input int which);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            r = r << 1;
            r[0] = (which == 0) ? co[k][ch] : (which == 1) ? cp[k][ch] : cb[k][ch];
        end
        return r;
    endfunction

    function automatic int ones(input int ch, input int n, input int which);
        int c;
        c = 0;
        for (int k = 0; k < n; k++)
            c += int'((which == 0) ? co[k][ch] : cp[k][ch]);
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic wait_pend0();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge PCLK);
            if (PWM_PEND[0]) seen = 1'b1;
        end
        n_chk++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_pend0: got no pulse within 40 clocks want pulse");
        end
    endtask

    initial begin
        PRESET = 1'b1; PWM_DIV = '0; PWM_EN = '0; PWM_INV = 4'hF;
        PWM_PERIOD = '0; PWM_DUTY = '0;
        step(2);
        @(negedge PCLK);
        chk("reset_out", 32'(PWM_OUT), 32'h0);
        chk("reset_busy", 32'(PWM_BUSY), 32'h0);
        chk("reset_pend", 32'(PWM_PEND), 32'h0);
        step(1);
        PRESET = 1'b0;
        chk_on = 1'b1;
        step(3);

        // basic waveform, DIV=0
        PWM_INV = 4'h0;
        PWM_PERIOD[15:0] = 16'd3; PWM_DUTY[15:0] = 16'd2;
        PWM_EN = 4'b0001;
        step(2);
        cap(8);
        chk("basic_out", 32'(pk(0, 8, 0)), 32'b11001100);
        chk("basic_pend", 32'(pk(0, 8, 1)), 32'b00010001);
        chk("basic_busy", 32'(pk(0, 8, 2)), 32'b11111111);

        // DIV=1 doubles every level; then back to single-clock ticks
        PWM_DIV = 8'd1;
        step(20);
        cap(16);
        chk("div1_ones", 32'(ones(0, 16, 0)), 32'd8);
        chk("div1_pend", 32'(ones(0, 16, 1)), 32'd2);
        PWM_DIV = 8'd0;
        step(12);

        // duty written at cnt=1 only lands at the boundary
        wait_pend0();
        step(1);
        PWM_DUTY[15:0] = 16'd1;
        cap(8);
        chk("duty_shadow", 32'(pk(0, 8, 0)), 32'b11001000);

        // EN dropped at cnt=1: period drains out, pin follows live INV
        wait_pend0();
        step(1);
        PWM_EN[0] = 1'b0; PWM_INV[0] = 1'b1;
        cap(5);
        chk("drain_out", 32'(pk(0, 5, 0)), 32'b10001);
        chk("drain_pend", 32'(pk(0, 5, 1)), 32'b00010);
        chk("drain_busy", 32'(pk(0, 5, 2)), 32'b11110);
        step(4);

        // drop at cnt=1 and re-raise at cnt=2: no gap
        PWM_INV[0] = 1'b0; PWM_EN[0] = 1'b1;
        step(8);
        wait_pend0();
        step(1);
        PWM_EN[0] = 1'b0;
        step(1);
        PWM_EN[0] = 1'b1;
        cap(8);
        chk("rerun_busy", 32'(pk(0, 8, 2)), 32'hFF);
        chk("rerun_pend", 32'(pk(0, 8, 1)), 32'b00100010);
        chk("rerun_out", 32'(pk(0, 8, 0)), 32'b00010001);

        // edge cases on channels 1..3
        PWM_PERIOD[31:16] = 16'd3; PWM_DUTY[31:16] = 16'd5;
        PWM_PERIOD[47:32] = 16'd3; PWM_DUTY[47:32] = 16'd0;
        PWM_PERIOD[63:48] = 16'd0; PWM_DUTY[63:48] = 16'd1;
        PWM_EN = 4'hF;
        step(10);
        cap(8);
        chk("full_duty", 32'(pk(1, 8, 0)), 32'hFF);
        chk("zero_duty", 32'(pk(2, 8, 0)), 32'h00);
        chk("p0_out", 32'(pk(3, 8, 0)), 32'hFF);
        chk("p0_pend", 32'(pk(3, 8, 1)), 32'hFF);
        PWM_INV = 4'b1110;
        step(10);
        cap(8);
        chk("full_duty_inv", 32'(pk(1, 8, 0)), 32'h00);
        chk("zero_duty_inv", 32'(pk(2, 8, 0)), 32'hFF);
        chk("p0_out_inv", 32'(pk(3, 8, 0)), 32'h00);
        chk("p0_pend_inv", 32'(pk(3, 8, 1)), 32'hFF);

        // asynchronous reset mid-run, then restart from cnt=0
        PRESET = 1'b1;
        #1;
        chk("areset_out", 32'(PWM_OUT), 32'h0);
        chk("areset_busy", 32'(PWM_BUSY), 32'h0);
        chk("areset_pend", 32'(PWM_PEND), 32'h0);
        step(2);
        PWM_EN = 4'b0001; PWM_INV = 4'h0;
        PWM_DUTY[15:0] = 16'd2;
        PRESET = 1'b0;
        step(2);
        cap(8);
        chk("restart_out", 32'(pk(0, 8, 0)), 32'b11001100);
        chk("restart_pend", 32'(pk(0, 8, 1)), 32'b00010001);
        step(4);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_sched_ctrl.md
# pwm_sched_ctrl

Time-base and channel sequencer for the 4-channel PWM peripheral. It consumes the register-file outputs (divisor, enable, invert, period, duty) and generates the prescaler tick and the per-channel period counters. It applies configuration changes only at period boundaries through shadow registers, and drives the PWM pins, busy flags and period-end event pulses. It sits between the APB register slave and the pads/interrupt logic.

## Interface
- P_NUM_CH, 4, number of channels
- P_CNT_WIDTH, 16, period/duty counter width
- P_DIV_WIDTH, 8, prescaler divisor width
- One clock; reset is asynchronous and active-high.
- PCLK  in  1  clock
- PRESET  in  1  asynchronous, active-high reset
- PWM_DIV  in  P_DIV_WIDTH  prescaler divisor; tick every PWM_DIV+1 clocks
- PWM_EN  in  P_NUM_CH  per-channel enable (level)
- PWM_INV  in  P_NUM_CH  per-channel output inversion
- PWM_PERIOD  in  P_NUM_CH*P_CNT_WIDTH  flattened; channel i at [i*16 +: 16]; period = value+1 ticks
- PWM_DUTY  in  P_NUM_CH*P_CNT_WIDTH  flattened; active ticks per period
- PWM_OUT  out  P_NUM_CH  registered PWM pin drive
- PWM_BUSY  out  P_NUM_CH  channel in RUN or DRAIN
- PWM_PEND  out  P_NUM_CH  one-PCLK pulse at each completed period

## Operation
- Prescaler: div_cnt counts 0..div_sh. tick = (div_cnt == div_sh), then div_cnt <= 0. div_sh reloads from PWM_DIV on every tick, so a new divisor takes effect after the current tick interval.
- Channel FSM states: IDLE, RUN, DRAIN. All transitions and counter changes occur only on tick.
  - IDLE: if PWM_EN[i], load period_sh/duty_sh/inv_sh from inputs, cnt <= 0, go to RUN.
  - RUN: if cnt == period_sh, this is the period end: pulse PEND, reload all shadows, cnt <= 0. Otherwise cnt++. If PWM_EN[i] is low on a tick that is not a period end, go to DRAIN; the tick still advances cnt.
  - DRAIN: same counting as RUN. At period end go to IDLE with no reload, and pulse PEND. If PWM_EN[i] returns high before the period end, go back to RUN.
  - RUN with EN low at period end: pulse PEND and go to IDLE directly.
- Active level: act = (state != IDLE) && (cnt < duty_sh).
  - duty_sh = 0 gives 0 %.
  - duty_sh > period_sh gives 100 %.
  - period_sh = 0 gives a 1-tick period.
- Pin level:
  - RUN/DRAIN: PWM_OUT[i] <= act ^ inv_sh.
  - IDLE: PWM_OUT[i] <= PWM_INV[i] (live).
- Width rules: compares are unsigned P_CNT_WIDTH. cnt never exceeds period_sh, so there is no wrap beyond 0xFFFF. A period of 0xFFFF gives 65536 ticks.
- Mid-period writes to PERIOD/DUTY/INV are invisible until the next period end. Shadowed inputs are not sampled between boundaries.

## Timing
- Reset values:
  - PWM_OUT = 0, including when PWM_INV = 1.
  - PWM_BUSY = 0, PWM_PEND = 0.
  - All FSMs IDLE; div_cnt = 0; div_sh = 0; all shadows 0.
- PWM_OUT and PWM_PEND are registered, with 1 PCLK latency from the state/cnt they reflect.
- PWM_BUSY is registered: high in the cycle after IDLE→RUN and low in the cycle after →IDLE.
- Start latency with DIV = 0: EN rises at edge N, sampled at edge N+1 (enters RUN), PWM_OUT active after edge N+2.
- With DIV = d, worst-case start latency is d+2 clocks.
- Simultaneous EN drop and period end on the same tick: go to IDLE and pulse PEND; no DRAIN cycle.
- Channels that are enabled on the same tick stay phase-aligned indefinitely, because they share one tick.
- Asserting PRESET mid-period forces the reset values immediately (asynchronous). There is no completion of the period.

## Structure
- Package pwm_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN} pwm_ch_state_t
  - localparams for the default widths and channel count
- Sub-module pwm_ch_ctrl, one instance per channel via a generate loop. It holds the FSM, cnt, the shadows and the output/PEND/BUSY registers.
- The top level holds only the prescaler and the flattened-bus slicing.

## Test plan
- DIV=0, PERIOD0=3, DUTY0=2, INV0=0, EN0=1 → PWM_OUT[0] repeats 1,1,0,0. PEND[0] pulses every 4 clocks. BUSY[0] goes high 1 clock after entering RUN.
- DIV=1, same config → each level is held 2 clocks (1,1,1,1,0,0,0,0). Change DIV to 0 mid-interval → 1-clock ticks start right after the next tick.
- Running with PERIOD=3, DUTY=2, write DUTY=1 at cnt=1 → current period stays 1,1,0,0; next period is 1,0,0,0.
- Drop EN at cnt=1 → the period completes (DRAIN), PEND pulses once, then BUSY=0 and PWM_OUT = PWM_INV. Reassert EN at cnt=2 of a second run → stays in RUN with no gap.
- Edge cases:
  - DUTY=5, PERIOD=3 → constant 1.
  - DUTY=0 → constant 0.
  - INV=1 → complement of the above.
  - PERIOD=0, DUTY=1 → constant 1 with PEND every tick.
- Assert PRESET during RUN with INV=1 → PWM_OUT/BUSY/PEND go to 0 immediately. After release with EN=1 → restart from cnt=0.
